// File: rtl/text_writer_pkg.sv
// Shared constants, FSM state type and cell addressing for the text_writer block.
package text_writer_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = 2400;

  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [6:0] CHAR_CR    = 7'h0D;
  localparam logic [6:0] CHAR_BLOCK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // row*80 + col without a multiplier: row*64 + row*16 + col.
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [11:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/text_writer_btn_debounce.sv
// Two-flop synchronizer plus hold-time debouncer; emits a one-cycle pulse
// when the debounced level rises.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the current level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_writer.sv
// 80x30 character buffer with debounced write/clear buttons and a 1-cycle read port.
// Optional cursor blink is enabled by defining TEXT_WRITER_CURSOR_BLINK_EN.
module text_writer
  import text_writer_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switch,
  input  logic       btn_write,
  input  logic       btn_clear,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [6:0] rd_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy,
  output logic       cursor_vis,
  output state_t     fsm_state
);

  // Valid/ready: the buttons carry no handshake; a write or clear event is a
  // single-cycle pulse that is consumed only in IDLE and otherwise dropped.

  state_t      state, state_n;
  logic [11:0] sweep_addr, addr_n;
  logic [6:0]  cur_col, col_n;
  logic [4:0]  cur_row, row_n;
  logic [4:0]  next_row;
  logic        wr_ev, clr_ev;
  logic        we;
  logic [11:0] waddr;
  logic [6:0]  wdata;
  logic        unused_sw;

  logic [6:0] mem [CELLS];

  assign unused_sw = switch[7];

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_write (
    .clk (clk),
    .rst (reset),
    .btn (btn_write),
    .rise(wr_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk (clk),
    .rst (reset),
    .btn (btn_clear),
    .rise(clr_ev)
  );

  // Reset lands in CLEAR so the RAM is blanked by sweeping rather than reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
    end else begin
      state      <= state_n;
      sweep_addr <= addr_n;
      cur_col    <= col_n;
      cur_row    <= row_n;
    end
  end

  assign next_row = (cur_row == 5'(ROWS - 1)) ? 5'd0 : cur_row + 5'd1;

  always_comb begin
    state_n = state;
    addr_n  = sweep_addr;
    col_n   = cur_col;
    row_n   = cur_row;
    we      = 1'b0;
    waddr   = cell_addr(cur_row, cur_col);
    wdata   = switch[6:0];
    case (state)
      IDLE: begin
        if (clr_ev) begin
          state_n = CLEAR;
          addr_n  = '0;
          col_n   = '0;
          row_n   = '0;
        end else if (wr_ev) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        state_n = IDLE;
        if (switch[6:0] == CHAR_CR) begin
          col_n = '0;
          row_n = next_row;
        end else begin
          we = 1'b1;
          if (cur_col == 7'(COLS - 1)) begin
            col_n = '0;
            row_n = next_row;
          end else begin
            col_n = cur_col + 7'd1;
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = sweep_addr;
        wdata = CHAR_SPACE;
        if (sweep_addr == 12'(CELLS - 1)) begin
          state_n = IDLE;
          addr_n  = '0;
        end else begin
          addr_n = sweep_addr + 12'd1;
        end
      end
      default: begin
        state_n = CLEAR;
        addr_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic        rd_ok;
  logic [11:0] raddr;
  assign rd_ok = (rd_row < 5'(ROWS)) && (rd_col < 7'(COLS));
  assign raddr = cell_addr(rd_row, rd_col);

`ifdef TEXT_WRITER_CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt  <= '0;
      cursor_vis <= ~cursor_vis;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             rd_char <= CHAR_SPACE;
    else if (!rd_ok)                                       rd_char <= CHAR_SPACE;
    else if (cursor_vis && raddr == cell_addr(cur_row, cur_col)) rd_char <= CHAR_BLOCK;
    else                                                   rd_char <= mem[raddr];
  end
`else
  localparam int unused_blink = BLINK_CYCLES;
  assign cursor_vis = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_char <= CHAR_SPACE;
    else if (!rd_ok) rd_char <= CHAR_SPACE;
    else             rd_char <= mem[raddr];
  end
`endif

  assign busy       = (state == CLEAR);
  assign cursor_col = cur_col;
  assign cursor_row = cur_row;
  assign fsm_state  = state;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: screen model with linear cursor arithmetic,
// per-cycle cursor/busy compare, and literal checks on key cells.
module tb_text_writer;
  import text_writer_pkg::*;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] switch = 8'h00;
  logic       btn_write = 1'b0;
  logic       btn_clear = 1'b0;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic [6:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       cursor_vis;
  state_t     fsm_state;

  text_writer #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .btn_write (btn_write),
    .btn_clear (btn_clear),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_char   (rd_char),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy),
    .cursor_vis(cursor_vis),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // screen model
  logic [6:0] m_mem [2400];
  int         m_row, m_col;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 2400; i++) m_mem[i] = 7'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void m_write(input int ch);
    int pos;
    if (ch == 'h0D) begin
      m_row = (m_row + 1) % 30;
      m_col = 0;
    end else begin
      pos = m_row * 80 + m_col;
      m_mem[pos] = 7'(ch);
      pos = (pos + 1) % 2400;
      m_row = pos / 80;
      m_col = pos % 80;
    end
  endfunction

  // driver: one debounced write press
  task automatic write_char(input int ch);
    chk_en = 1'b0;
    switch = 8'(ch);
    btn_write = 1'b1;
    tick(10);
    btn_write = 1'b0;
    tick(12);
    m_write(ch);
    chk_en = 1'b1;
  endtask

  // scoreboard read: expected value pushed, compared after exactly one edge
  task automatic read_cell(input int row, input int col, input string name);
    logic [6:0] e;
    int act;
    e = (row < 30 && col < 80) ? m_mem[row * 80 + col] : 7'h20;
    rd_row = 5'(row);
    rd_col = 7'(col);
    exp_q.push_back(e);
    tick(1);
    e = exp_q.pop_front();
    act = int'(rd_char);
`ifdef TEXT_WRITER_CURSOR_BLINK_EN
    if (row == m_row && col == m_col && rd_char == 7'h7F) act = int'(e);
`endif
    check(name, act, int'(e));
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick(1);
      n++;
    end
  endtask

  // per-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("cursor_col", int'(cursor_col), m_col);
      check("cursor_row", int'(cursor_row), m_row);
      check("busy_idle", int'(busy), 0);
`ifndef TEXT_WRITER_CURSOR_BLINK_EN
      check("cursor_vis_tied", int'(cursor_vis), 0);
`endif
    end
  end

  initial begin
    int n;
    m_clear();
    tick(3);
    check("rst_rd_char", int'(rd_char), 'h20);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor_col", int'(cursor_col), 0);
    reset = 1'b0;
    wait_sweep(n);
    check("init_sweep_len", n, 2400);
    chk_en = 1'b1;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) read_cell(r, c, "init_blank");
    check("init_cursor_lit", int'({cursor_row, cursor_col}), 0);

`ifdef TEXT_WRITER_CURSOR_BLINK_EN
    begin
      int blocks;
      blocks = 0;
      rd_row = 5'd0;
      rd_col = 7'd0;
      tick(1);
      for (int i = 0; i < 32; i++) begin
        tick(1);
        if (rd_char == 7'h7F) blocks++;
        else check("blink_data", int'(rd_char), 'h20);
      end
      check("blink_block_count", blocks, 16);
    end
`endif

    write_char('h41);
    read_cell(0, 0, "cell00");
    check("cell00_lit", int'(rd_char), 'h41);
    check("cursor_after_A_col", int'(cursor_col), 1);
    check("cursor_after_A_row", int'(cursor_row), 0);

    // 2-cycle glitch must not produce a write
    btn_write = 1'b1;
    tick(2);
    btn_write = 1'b0;
    tick(12);
    check("glitch_cursor_lit", int'(cursor_col), 1);

    for (int i = 0; i < 5; i++) write_char('h0D);
    for (int i = 0; i < 10; i++) write_char('h61 + i);
    read_cell(4, 80, "oob_col80");
    read_cell(4, 89, "oob_col89");
    read_cell(5, 9, "cell_5_9");
    write_char('h0D);
    read_cell(5, 10, "cr_cell_5_10");
    check("cr_cell_lit", int'(rd_char), 'h20);
    check("cr_cursor_col_lit", int'(cursor_col), 0);
    check("cr_cursor_row_lit", int'(cursor_row), 6);

    for (int i = 0; i < 23; i++) write_char('h0D);
    for (int i = 0; i < 79; i++) write_char('h30 + (i % 40));
    check("pre_wrap_col_lit", int'(cursor_col), 79);
    check("pre_wrap_row_lit", int'(cursor_row), 29);
    write_char('h42);
    read_cell(29, 79, "cell_29_79");
    check("cell_29_79_lit", int'(rd_char), 'h42);
    read_cell(29, 0, "cell_29_0");
    read_cell(29, 40, "cell_29_40");
    check("wrap_cursor_lit", int'({cursor_row, cursor_col}), 0);

    // async reset from IDLE, then reset again mid-sweep
    write_char('h5A);
    read_cell(0, 0, "cell00_Z");
    chk_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async_rst_col", int'(cursor_col), 0);
    check("async_rst_rd_char", int'(rd_char), 'h20);
    check("async_rst_busy", int'(busy), 1);
    check("async_rst_vis", int'(cursor_vis), 0);
    tick(2);
    reset = 1'b0;
    tick(1000);
    #3 reset = 1'b1;
    #1;
    check("mid_sweep_rst_busy", int'(busy), 1);
    tick(2);
    reset = 1'b0;
    wait_sweep(n);
    check("restart_sweep_len", n, 2400);
    m_clear();
    chk_en = 1'b1;
    read_cell(0, 0, "post_rst_cell00");
    read_cell(29, 79, "post_rst_cell_29_79");

    // simultaneous write+clear: clear wins; write during busy is dropped
    write_char('h5A);
    chk_en = 1'b0;
    btn_write = 1'b1;
    btn_clear = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick(1);
      n++;
    end
    check("clr_started", int'(busy), 1);
    btn_write = 1'b0;
    btn_clear = 1'b0;
    n = busy ? 1 : 0;
    while (busy && n < 5000) begin
      if (n == 100) btn_write = 1'b1;
      if (n == 110) btn_write = 1'b0;
      tick(1);
      if (busy) n++;
    end
    check("clr_sweep_len", n, 2400);
    m_clear();
    tick(12);
    chk_en = 1'b1;
    read_cell(0, 0, "clr_cell00");
    read_cell(0, 1, "clr_cell01");
    check("clr_cursor_lit", int'({cursor_row, cursor_col}), 0);

    read_cell(0, 90, "oob_col90");
    read_cell(30, 0, "oob_row30");
    read_cell(31, 127, "oob_max");
    tick(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, debounce hold time in clk cycles (10 ms at 100 MHz).
REQ-002 Parameter BLINK_CYCLES, default 25000000, cursor blink half-period in clk cycles.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 switch  input  8  [6:0] character code to write; [7] reserved, ignored.
REQ-006 btn_write  input  1  raw pushbutton that requests a character write; asynchronous to clk.
REQ-007 btn_clear  input  1  raw pushbutton that requests a screen clear; asynchronous to clk.
REQ-008 rd_col  input  7  read column from the character generator, 0..79.
REQ-009 rd_row  input  5  read row from the character generator, 0..29.
REQ-010 rd_char  output  7  character code at (rd_row, rd_col), registered.
REQ-011 cursor_col  output  7  current write column.
REQ-012 cursor_row  output  5  current write row.
REQ-013 busy  output  1  high while a clear sweep runs.
REQ-014 cursor_vis  output  1  blink phase; high means the cursor cell is displayed as the block glyph.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer, then a debouncer that changes state only after DEB_CYCLES consecutive equal samples.
REQ-016 A write event SHALL be one clk pulse on the rising edge of debounced btn_write; a clear event SHALL be the same for btn_clear.
REQ-017 Storage SHALL be an 80x30 array of 7-bit cells, addressed row*80+col (12 bits), computed as (row<<6)+(row<<4)+col.
REQ-018 FSM states: IDLE, WRITE, CLEAR.
  - IDLE -> WRITE on a write event.
  - IDLE -> CLEAR on a clear event.
  - WRITE -> IDLE after 1 cycle.
  - CLEAR -> IDLE after the cell at address 2399 is written.
REQ-019 WRITE with switch[6:0] /= 0x0D SHALL store switch[6:0] at the cursor and advance the cursor.
  - Column 79 wraps to 0 and row increments.
  - Row 29 wraps to 0.
REQ-020 WRITE with switch[6:0] = 0x0D SHALL store nothing, set col=0 and increment row, with row 29 wrapping to 0.
REQ-021 CLEAR SHALL write 0x20 to one cell per cycle, addresses 0..2399 (2400 cycles), hold busy=1 throughout, and set the cursor to (0,0) on entry.
REQ-022 Write events arriving while busy=1 SHALL be discarded; clear events while busy=1 SHALL be discarded.
REQ-023 A write event and a clear event in the same cycle: clear wins and the write is discarded.
REQ-024 The read port SHALL have a latency of exactly 1 cycle, be independent of the write side, and return old data on a same-cycle read/write collision.
REQ-025 rd_row>29 or rd_col>79 SHALL return 0x20.

Reset
REQ-026 On reset assertion the following SHALL take effect immediately:
  - cursor_col=0, cursor_row=0.
  - rd_char=0x20.
  - cursor_vis=0.
  - synchronizers and debouncers cleared to 0.
  - blink counter 0.
REQ-027 The FSM SHALL reset to CLEAR with the sweep address at 0 and busy=1, so the array is blanked without resetting the RAM itself.
REQ-028 Reset asserted mid-CLEAR or mid-WRITE SHALL abort the operation and restart the sweep from address 0 after deassertion.

Configuration
REQ-029 Macro TEXT_WRITER_CURSOR_BLINK_EN: when defined, cursor_vis toggles every BLINK_CYCLES cycles.
  - While cursor_vis=1, a read of the cursor cell returns 0x7F.
REQ-030 When TEXT_WRITER_CURSOR_BLINK_EN is undefined:
  - cursor_vis is tied to 0.
  - No blink counter is built.
  - rd_char is pure array data.

Structure
REQ-031 Package text_writer_pkg SHALL hold:
  - COLS=80, ROWS=30, CELLS=2400.
  - CHAR_SPACE=0x20, CHAR_CR=0x0D, CHAR_BLOCK=0x7F.
  - the FSM state enum.
REQ-032 Sub-module btn_debounce (synchronizer plus debouncer, parameter DEB_CYCLES) SHALL be instantiated twice, once for btn_write and once for btn_clear.

Verification (DEB_CYCLES=4, BLINK_CYCLES=8)
REQ-033 Release reset -> busy=1 for 2400 cycles, then busy=0; read of every cell gives 0x20; cursor at (0,0).
REQ-034 switch=0x41, pulse btn_write 10 cycles -> cell (0,0)=0x41, cursor (0,1); 2-cycle glitch on btn_write -> no write.
REQ-035 Cursor at (29,79), write 0x42 -> cell (29,79)=0x42, cursor wraps to (0,0); switch=0x0D at (5,10) -> cursor (6,0), cell (5,10) unchanged.
REQ-036 btn_write and btn_clear debounced in the same cycle -> CLEAR runs, no write; btn_write during busy -> ignored.
REQ-037 Reset at sweep address 1000 -> sweep restarts at 0 and runs all 2400 cycles; rd_col=90 -> rd_char=0x20 one cycle later.
REQ-038 Macro defined, read cursor cell -> alternates between 0x7F and stored data every 8 cycles; macro undefined -> cursor_vis constant 0.
